image_frame_scheduler: RTL and testbench
========================================

Name: image_frame_scheduler

Overview:
- Command-driven sequencer placed in front of the image read/processing pipeline.
- Queues per-frame operation commands (op select, brightness value, threshold, sign) and issues them one frame at a time: applies the config, pulses start, then supervises the frame via the line-sync and done flags.
- Reports frame/line counts, a done interrupt pulse, and sticky timeout / line-count errors.

Parameters:
- CMD_DEPTH, 4, command FIFO depth; power of 2, ≥2.
- HEIGHT, 512, expected lines (dp_hsync rising edges) per frame.
- TIMEOUT, 400000, max HCLK cycles in RUN before abort. Nominal 512-line frame ≈ 377,445 cycles.
- TO_W, 20, watchdog counter width; must hold TIMEOUT.
- FRAME_GAP, 16, idle cycles enforced between frames; ≥1.

Ports:
- HCLK  in  1  clock
- HRESETn  in  1  async active-low reset
- sched_en  in  1  1 = allowed to launch new frames
- cmd_valid  in  1  command present
- cmd_ready  out  1  FIFO not full
- cmd_op  in  2  0 = pass, 1 = brightness, 2 = invert, 3 = threshold
- cmd_value  in  8  brightness value
- cmd_thresh  in  8  threshold
- cmd_sign  in  1  brightness sign (1 = add)
- dp_start  out  1  one-cycle frame start pulse
- dp_op  out  2  applied op, held stable for the whole frame
- dp_value  out  8  applied value, held stable
- dp_thresh  out  8  applied threshold, held stable
- dp_sign  out  1  applied sign, held stable
- dp_hsync  in  1  datapath line-active flag
- dp_done  in  1  datapath frame-done flag
- busy  out  1  high in LOAD/START/RUN/GAP
- frame_cnt  out  16  completed frames, wraps at 65535 -> 0
- line_cnt  out  10  lines seen in current/last frame
- irq_done  out  1  one-cycle pulse per frame completion
- err_timeout  out  1  sticky watchdog error
- err_lines  out  1  sticky: frame finished with line_cnt != HEIGHT
- err_clr  in  1  clears both sticky errors

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE. Exception: cmd_ready = 1 after reset.
- Reset asserted mid-frame aborts immediately; the queue is lost.
- FIFO:
  - Push when cmd_valid & cmd_ready. cmd_ready = !full.
  - A pop when full frees a slot; cmd_ready rises the next cycle.
  - Simultaneous push and pop while not full is legal; count is unchanged.
- FSM:
  - IDLE: if sched_en & !empty -> LOAD.
  - LOAD: pop the head entry into the dp_* registers; clear line_cnt and watchdog -> START.
  - START: dp_start = 1 for exactly this cycle -> RUN.
  - RUN:
    - Watchdog increments each cycle.
    - Rising edge of dp_hsync (registered previous value) increments line_cnt. line_cnt saturates at 1023.
    - On dp_done: irq_done pulses next cycle, frame_cnt += 1, and err_lines is set if line_cnt (including any edge in the same cycle) != HEIGHT -> GAP.
    - Else if watchdog == TIMEOUT-1: err_timeout = 1, no irq, frame_cnt unchanged -> GAP.
    - dp_done and timeout in the same cycle: done wins.
  - GAP: count FRAME_GAP cycles, then -> IDLE.
- Latency: earliest command push to dp_start is 3 cycles (FIFO write, IDLE sees non-empty, LOAD).
- sched_en low never aborts a frame in progress; it only blocks IDLE -> LOAD.
- dp_* config registers change only in LOAD. They hold their last values while idle.
- err_clr:
  - Clears sticky errors.
  - If err_clr coincides with a new error set, set wins.
- dp_done or dp_hsync activity outside RUN is ignored.
- line_cnt retains its value after the frame until the next LOAD.

Test Plan:
- Test config: HEIGHT=4, TIMEOUT=200, FRAME_GAP=3, and a behavioural datapath model giving 4 hsync pulses then done at cycle 60.
- Reset/default: hold HRESETn low 5 cycles -> all outputs 0, cmd_ready=1; release with no commands -> busy stays 0.
- Single frame: push op=1, value=100, sign=0 at cycle 0 -> dp_start pulse at cycle 3 with dp_value=100 stable through RUN; at done, irq_done one pulse, frame_cnt=1, line_cnt=4, no errors; busy drops 3 cycles after done.
- Queue full/back-to-back: push 5 commands with sched_en=0 -> cmd_ready=0 after 4; set sched_en=1 -> 4 frames execute in FIFO order (op 0,1,2,3) separated by exactly 3 gap cycles; cmd_ready=1 one cycle after first pop.
- Timeout: model never asserts done -> err_timeout=1 after 200 RUN cycles, frame_cnt unchanged, next queued frame still launches; err_clr pulse -> err_timeout=0.
- Line error and tie: model gives 3 hsync pulses then done -> err_lines=1, frame_cnt increments. Then assert done exactly on the timeout cycle -> irq_done pulses, err_timeout stays 0.
- Reset mid-frame: assert HRESETn at cycle 30 of RUN with 2 commands queued -> all outputs 0 immediately, FIFO empty, no dp_start after release.

Source files
------------

// File: rtl/image_frame_scheduler.sv
// image_frame_scheduler: queues per-frame datapath commands and launches/supervises one frame at a time
// with a line counter, a watchdog and sticky error flags.
module image_frame_scheduler #(
    parameter int CMD_DEPTH = 4,
    parameter int HEIGHT    = 512,
    parameter int TIMEOUT   = 400000,
    parameter int TO_W      = 20,
    parameter int FRAME_GAP = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        sched_en,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [7:0]  cmd_value,
    input  logic [7:0]  cmd_thresh,
    input  logic        cmd_sign,
    output logic        dp_start,
    output logic [1:0]  dp_op,
    output logic [7:0]  dp_value,
    output logic [7:0]  dp_thresh,
    output logic        dp_sign,
    input  logic        dp_hsync,
    input  logic        dp_done,
    output logic        busy,
    output logic [15:0] frame_cnt,
    output logic [9:0]  line_cnt,
    output logic        irq_done,
    output logic        err_timeout,
    output logic        err_lines,
    input  logic        err_clr
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int GW = $clog2(FRAME_GAP) + 1;
    typedef enum logic [2:0] {IDLE, LOAD, START, RUN, GAP} state_t;
    state_t state, state_nx;
    logic [18:0]   mem [CMD_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic [TO_W-1:0] wd;
    logic [GW-1:0] gap_cnt;
    logic [9:0]    line_nx;
    logic          full, empty, push, pop, hsync_q, rise, done_hit, to_hit;
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty     = wr_ptr == rd_ptr;
    assign cmd_ready = !full;
    assign push      = cmd_valid && !full;
    assign dp_start  = state == START;
    assign busy      = state != IDLE;
    assign rise      = state == RUN && dp_hsync && !hsync_q;
    // line count including an edge arriving in the same cycle as done
    assign line_nx   = rise ? (line_cnt == 10'h3FF ? line_cnt : line_cnt + 10'd1) : line_cnt;
    always_comb begin
        state_nx = state;
        pop      = 1'b0;
        done_hit = 1'b0;
        to_hit   = 1'b0;
        case (state)
            IDLE:    if (sched_en && !empty) state_nx = LOAD;
            LOAD: begin
                pop      = 1'b1;
                state_nx = START;
            end
            START:   state_nx = RUN;
            RUN: begin
                if (dp_done) begin
                    done_hit = 1'b1;
                    state_nx = GAP;
                end else if (wd == TO_W'(TIMEOUT - 1)) begin
                    to_hit   = 1'b1;
                    state_nx = GAP;
                end
            end
            GAP:     if (gap_cnt == GW'(FRAME_GAP - 1)) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge HCLK) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {cmd_op, cmd_value, cmd_thresh, cmd_sign};
    end
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            dp_op       <= '0;
            dp_value    <= '0;
            dp_thresh   <= '0;
            dp_sign     <= 1'b0;
            hsync_q     <= 1'b0;
            line_cnt    <= '0;
            wd          <= '0;
            gap_cnt     <= '0;
            irq_done    <= 1'b0;
            frame_cnt   <= '0;
            err_lines   <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state    <= state_nx;
            hsync_q  <= dp_hsync;
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) begin
                rd_ptr <= rd_ptr + (AW+1)'(1);
                {dp_op, dp_value, dp_thresh, dp_sign} <= mem[rd_ptr[AW-1:0]];
            end
            line_cnt    <= pop ? '0 : line_nx;
            wd          <= pop ? '0 : (state == RUN ? wd + TO_W'(1) : wd);
            gap_cnt     <= state == GAP ? gap_cnt + GW'(1) : '0;
            irq_done    <= done_hit;
            if (done_hit) frame_cnt <= frame_cnt + 16'd1;
            // a new error in the same cycle as err_clr stays set
            err_lines   <= (done_hit && line_nx != 10'(HEIGHT)) ? 1'b1 : (err_clr ? 1'b0 : err_lines);
            err_timeout <= to_hit ? 1'b1 : (err_clr ? 1'b0 : err_timeout);
        end
    end
endmodule

// File: tb/tb_image_frame_scheduler.sv
// tb_image_frame_scheduler: directed stimulus with a queue scoreboard checked by an independent monitor.
module tb_image_frame_scheduler;
    localparam int H = 4, TO = 200, FG = 3;
    logic        HCLK = 0, HRESETn = 0, sched_en = 0, cmd_valid = 0, cmd_sign = 0;
    logic [1:0]  cmd_op = 0;
    logic [7:0]  cmd_value = 0, cmd_thresh = 0;
    logic        dp_hsync, dp_done, err_clr = 0;
    logic        cmd_ready, dp_start, dp_sign, busy, irq_done, err_timeout, err_lines;
    logic [1:0]  dp_op;
    logic [7:0]  dp_value, dp_thresh;
    logic [15:0] frame_cnt;
    logic [9:0]  line_cnt;
    int total = 0, bad = 0, n_start = 0, m_lines = 4, m_done = 60;
    logic [18:0] exp_cfg[$];
    logic [27:0] exp_done[$];
    logic [18:0] cur;
    logic        started = 0, unstable = 0;

    always #5 HCLK = ~HCLK;

    image_frame_scheduler #(.CMD_DEPTH(4), .HEIGHT(H), .TIMEOUT(TO), .TO_W(20), .FRAME_GAP(FG)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .sched_en(sched_en), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_value(cmd_value), .cmd_thresh(cmd_thresh), .cmd_sign(cmd_sign),
        .dp_start(dp_start), .dp_op(dp_op), .dp_value(dp_value), .dp_thresh(dp_thresh), .dp_sign(dp_sign),
        .dp_hsync(dp_hsync), .dp_done(dp_done), .busy(busy), .frame_cnt(frame_cnt), .line_cnt(line_cnt),
        .irq_done(irq_done), .err_timeout(err_timeout), .err_lines(err_lines), .err_clr(err_clr)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic pick(input int sel);
        return sel == 0 ? dp_start : sel == 1 ? irq_done : sel == 2 ? !busy : err_timeout;
    endfunction

    task automatic wait_for(input string nm, input int sel, input int lim, output int n);
        n = 0;
        while (!pick(sel) && n < lim) begin
            @(negedge HCLK);
            n++;
        end
        if (!pick(sel)) chk({nm, "_wait_expired"}, 0, 1);
    endtask

    task automatic send(input logic [1:0] op, input logic [7:0] v, input logic [7:0] t, input logic s);
        cmd_valid = 1; cmd_op = op; cmd_value = v; cmd_thresh = t; cmd_sign = s;
        if (cmd_ready) exp_cfg.push_back({op, v, t, s});
        @(negedge HCLK);
        cmd_valid = 0;
    endtask

    function automatic logic [49:0] outs();
        return {dp_start, dp_op, dp_value, dp_thresh, dp_sign, busy, frame_cnt, line_cnt, irq_done, err_timeout, err_lines};
    endfunction

    // datapath model: hsync pulses of 4 cycles every 10 RUN cycles, done on RUN cycle m_done (0 = never)
    initial begin
        int lim, nl, nd;
        dp_hsync = 0; dp_done = 0;
        forever begin
            @(negedge HCLK);
            if (HRESETn && dp_start) begin
                nl = m_lines; nd = m_done;
                lim = nd > 0 ? nd + 1 : TO + 2;
                for (int k = 1; k <= lim; k++) begin
                    @(negedge HCLK);
                    if (!HRESETn) break;
                    dp_hsync = k >= 10 && k < 10 + 10 * nl && k % 10 < 4;
                    dp_done  = k == nd;
                end
                dp_hsync = 0; dp_done = 0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge HCLK);
            if (!HRESETn) begin
                started = 0; unstable = 0;
            end else begin
                if (dp_start) begin
                    n_start++;
                    if (exp_cfg.size() == 0) chk("start_unexpected", 1, 0);
                    else chk("cfg", {dp_op, dp_value, dp_thresh, dp_sign}, exp_cfg.pop_front());
                    cur = {dp_op, dp_value, dp_thresh, dp_sign};
                    started = 1; unstable = 0;
                end else if (started && {dp_op, dp_value, dp_thresh, dp_sign} != cur) unstable = 1;
                if (irq_done) begin
                    chk("cfg_stable", unstable, 0);
                    if (exp_done.size() == 0) chk("irq_unexpected", 1, 0);
                    else chk("done", {frame_cnt, line_cnt, err_lines, err_timeout}, exp_done.pop_front());
                end
            end
        end
    end

    initial begin
        int n, s0;
        repeat (5) @(negedge HCLK);
        chk("reset_outs", outs(), 0);
        chk("reset_ready", cmd_ready, 1);
        HRESETn = 1;
        repeat (5) @(negedge HCLK);
        chk("idle_busy", busy, 0);
        // single frame
        sched_en = 1; m_lines = 4; m_done = 60;
        exp_done.push_back({16'd1, 10'd4, 1'b0, 1'b0});
        send(1, 100, 0, 0);
        wait_for("start1", 0, 20, n);
        chk("latency", n + 1, 3);
        wait_for("irq1", 1, 200, n);
        @(negedge HCLK);
        chk("irq_pulse", irq_done, 0);
        wait_for("idle1", 2, 50, n);
        chk("busy_drop", n + 1, FG);
        // queue full, then back-to-back frames in order
        sched_en = 0;
        for (int i = 0; i < 4; i++) begin
            exp_done.push_back({16'(2 + i), 10'd4, 1'b0, 1'b0});
            send(2'(i), 8'(10 * i + 1), 8'(20 * i + 2), 1'(i));
        end
        chk("full_ready", cmd_ready, 0);
        send(0, 99, 99, 1);
        sched_en = 1;
        @(negedge HCLK);
        chk("ready_at_pop", cmd_ready, 0);
        @(negedge HCLK);
        chk("ready_after_pop", cmd_ready, 1);
        for (int f = 0; f < 4; f++) begin
            wait_for("irq_q", 1, 200, n);
            if (f < 3) begin
                wait_for("start_q", 0, 50, n);
                chk("frame_gap", n, FG + 2);
            end
        end
        wait_for("idle_q", 2, 50, n);
        // timeout, then next queued frame, err_clr
        m_done = 0;
        exp_done.push_back({16'd6, 10'd4, 1'b0, 1'b0});
        send(3, 0, 50, 0);
        send(2, 7, 8, 1);
        wait_for("start_to", 0, 20, n);
        wait_for("err_to", 3, 400, n);
        chk("timeout_cycles", n, TO + 1);
        chk("timeout_frames", frame_cnt, 5);
        m_done = 60;
        wait_for("start_after_to", 0, 50, n);
        err_clr = 1;
        @(negedge HCLK);
        err_clr = 0;
        chk("err_to_clr", err_timeout, 0);
        wait_for("irq_after_to", 1, 200, n);
        wait_for("idle_to", 2, 50, n);
        // line count error
        m_lines = 3;
        exp_done.push_back({16'd7, 10'd3, 1'b1, 1'b0});
        send(1, 20, 0, 1);
        wait_for("irq_le", 1, 200, n);
        wait_for("idle_le", 2, 50, n);
        err_clr = 1;
        @(negedge HCLK);
        err_clr = 0;
        chk("err_lines_clr", err_lines, 0);
        // done on the timeout cycle
        m_lines = 4; m_done = TO;
        exp_done.push_back({16'd8, 10'd4, 1'b0, 1'b0});
        send(0, 0, 0, 0);
        wait_for("irq_tie", 1, 400, n);
        wait_for("idle_tie", 2, 50, n);
        chk("tie_no_timeout", err_timeout, 0);
        // reset mid-frame with two commands queued
        m_done = 60;
        send(1, 5, 0, 1);
        send(2, 6, 0, 0);
        send(3, 0, 77, 0);
        wait_for("start_rst", 0, 20, n);
        repeat (30) @(negedge HCLK);
        HRESETn = 0;
        #1;
        chk("rst_outs", outs(), 0);
        chk("rst_ready", cmd_ready, 1);
        exp_cfg.delete();
        repeat (3) @(negedge HCLK);
        HRESETn = 1;
        s0 = n_start;
        repeat (60) @(negedge HCLK);
        chk("no_start_after_rst", n_start - s0, 0);
        chk("busy_after_rst", busy, 0);
        chk("cfg_queue_left", exp_cfg.size(), 0);
        chk("done_queue_left", exp_done.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
